// File: rtl/freq_gate_controller.sv
`default_nettype none
// ============================================================================
// Module  : freq_gate_controller
// Brief   : Gated frequency measurement sequencer driving an external counter.
// Revision: 1.0 - initial release
// ============================================================================
module freq_gate_controller #(
   parameter int CNT_W  = 32,
   parameter int GATE_W = 32,
   parameter int SETTLE = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              cont_i,
   input  logic [GATE_W-1:0] gate_len_i,
   input  logic [CNT_W-1:0]  count_i,
   input  logic              result_ack_i,
   output logic              counter_clr_o,
   output logic              counter_en_o,
   output logic [CNT_W-1:0]  result_o,
   output logic              result_valid_o,
   output logic              busy_o,
   output logic              overrun_o,
   output logic              sat_o,
   output logic              err_o
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_GATE   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_LATCH  = 3'd4;

   localparam logic [3:0]        SETTLE_LD = 4'(SETTLE);
   localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);

   logic [2:0]        state_q, state_d;
   logic [GATE_W-1:0] gate_len_q, gate_len_d;
   logic [GATE_W-1:0] timer_q, timer_d;
   logic [3:0]        settle_q, settle_d;
   logic              clr_q, clr_d;
   logic              en_q, en_d;
   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  result_q, result_d;
   logic              valid_q, valid_d;
   logic              ovr_q, ovr_d;
   logic              sat_q, sat_d;
   logic              err_q, err_d;

   logic w_start_ok;
   logic w_start_bad;
   logic w_latch;

   // Abort outranks start, so an aborted start neither arms nor flags an error.
   assign w_start_ok  = (state_q == S_IDLE) && start_i && !abort_i && (gate_len_i != '0);
   assign w_start_bad = (state_q == S_IDLE) && start_i && !abort_i && (gate_len_i == '0);
   assign w_latch     = (state_q == S_LATCH);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (w_start_ok) state_d = S_CLEAR;
         S_CLEAR:  state_d = abort_i ? S_IDLE : S_GATE;
         S_GATE: begin
            if (abort_i)                   state_d = S_IDLE;
            else if (timer_q == GATE_ONE)  state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (abort_i)                   state_d = S_IDLE;
            else if (settle_q == 4'd1)     state_d = S_LATCH;
         end
         S_LATCH:  state_d = (cont_i && !abort_i) ? S_CLEAR : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Timer counts down to 1, so an all-ones gate length never wraps.
   always_comb begin
      gate_len_d = w_start_ok ? gate_len_i : gate_len_q;
      timer_d    = timer_q;
      settle_d   = settle_q;
      if (state_q == S_CLEAR) timer_d = gate_len_q;
      if (state_q == S_GATE) begin
         timer_d  = timer_q - GATE_ONE;
         settle_d = SETTLE_LD;
      end
      if (state_q == S_SETTLE) settle_d = settle_q - 4'd1;

      clr_d  = (state_d == S_CLEAR);
      en_d   = (state_d == S_GATE);
      busy_d = (state_d != S_IDLE);
      err_d  = w_start_bad;

      result_d = w_latch ? count_i : result_q;
      sat_d    = w_latch ? (count_i == {CNT_W{1'b1}}) : sat_q;
      if (w_latch)           valid_d = 1'b1;
      else if (result_ack_i) valid_d = 1'b0;
      else                   valid_d = valid_q;

      if (w_start_ok)                               ovr_d = 1'b0;
      else if (w_latch && valid_q && !result_ack_i) ovr_d = 1'b1;
      else                                          ovr_d = ovr_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gate_len_q <= '0;
         timer_q    <= '0;
         settle_q   <= '0;
         clr_q      <= 1'b0;
         en_q       <= 1'b0;
         busy_q     <= 1'b0;
         result_q   <= '0;
         valid_q    <= 1'b0;
         ovr_q      <= 1'b0;
         sat_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         gate_len_q <= gate_len_d;
         timer_q    <= timer_d;
         settle_q   <= settle_d;
         clr_q      <= clr_d;
         en_q       <= en_d;
         busy_q     <= busy_d;
         result_q   <= result_d;
         valid_q    <= valid_d;
         ovr_q      <= ovr_d;
         sat_q      <= sat_d;
         err_q      <= err_d;
      end
   end

   assign counter_clr_o  = clr_q;
   assign counter_en_o   = en_q;
   assign result_o       = result_q;
   assign result_valid_o = valid_q;
   assign busy_o         = busy_q;
   assign overrun_o      = ovr_q;
   assign sat_o          = sat_q;
   assign err_o          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_gate_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_freq_gate_controller
// Brief   : Directed scoreboard bench for freq_gate_controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_freq_gate_controller;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        cont;
   logic [31:0] gate_len;
   logic [31:0] count_in;
   logic        ack;
   logic        counter_clr_o;
   logic        counter_en_o;
   logic [31:0] result_o;
   logic        result_valid_o;
   logic        busy_o;
   logic        overrun_o;
   logic        sat_o;
   logic        err_o;

   freq_gate_controller #(.CNT_W(32), .GATE_W(32), .SETTLE(2)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .start_i        (start),
      .abort_i        (abort),
      .cont_i         (cont),
      .gate_len_i     (gate_len),
      .count_i        (count_in),
      .result_ack_i   (ack),
      .counter_clr_o  (counter_clr_o),
      .counter_en_o   (counter_en_o),
      .result_o       (result_o),
      .result_valid_o (result_valid_o),
      .busy_o         (busy_o),
      .overrun_o      (overrun_o),
      .sat_o          (sat_o),
      .err_o          (err_o)
   );

   typedef struct {
      logic [31:0] res;
      logic        sat;
      logic        ovr;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int en_cnt = 0;
   int clr_cnt = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (counter_en_o)  en_cnt  <= en_cnt + 1;
      if (counter_clr_o) clr_cnt <= clr_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int budget);
      int i;
      i = 0;
      while (busy_o && i < budget) begin
         tick(1);
         i++;
      end
      if (busy_o) chk("idle_timeout", 32'd1, 32'd0);
   endtask

   // Monitor: a new result is presented when result_valid rises or the value changes.
   logic        prev_rv  = 1'b0;
   logic [31:0] prev_res = '0;
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && result_valid_o && (!prev_rv || result_o != prev_res)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", result_o, 32'hDEAD_BEEF);
         end else begin
            e = exp_q.pop_front();
            chk("result", result_o, e.res);
            chk("sat", {31'd0, sat_o}, {31'd0, e.sat});
            chk("overrun", {31'd0, overrun_o}, {31'd0, e.ovr});
            if (e.cyc >= 0) chk("result_cycle", cyc, e.cyc);
         end
      end
      prev_rv  <= result_valid_o;
      prev_res <= result_o;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, e0, c0;
      rst_n = 1'b0; start = 0; abort = 0; cont = 0; gate_len = 0; count_in = 0; ack = 0;
      tick(3);
      chk("rst_clr",   {31'd0, counter_clr_o},  0);
      chk("rst_en",    {31'd0, counter_en_o},   0);
      chk("rst_res",   result_o,                0);
      chk("rst_valid", {31'd0, result_valid_o}, 0);
      chk("rst_busy",  {31'd0, busy_o},         0);
      chk("rst_ovr",   {31'd0, overrun_o},      0);
      chk("rst_sat",   {31'd0, sat_o},          0);
      chk("rst_err",   {31'd0, err_o},          0);
      rst_n = 1'b1;
      tick(2);

      // Single-shot gate of 50, count 25 presented after the gate closes.
      k = cyc; e0 = en_cnt; c0 = clr_cnt;
      gate_len = 50; count_in = 0; start = 1;
      exp_q.push_back('{32'd25, 1'b0, 1'b0, k + 55});
      tick(1); start = 0; gate_len = 7;
      tick(52); count_in = 25;
      wait_idle(100);
      chk("t1_en_cycles",  en_cnt - e0, 50);
      chk("t1_clr_cycles", clr_cnt - c0, 1);
      chk("t1_busy_after", {31'd0, busy_o}, 0);
      ack = 1; tick(1); ack = 0;
      chk("t1_ack_clears", {31'd0, result_valid_o}, 0);

      // Zero gate length is rejected with a one-cycle error.
      c0 = clr_cnt;
      gate_len = 0; start = 1; tick(1); start = 0;
      chk("t2_err_pulse", {31'd0, err_o}, 1);
      chk("t2_busy",      {31'd0, busy_o}, 0);
      tick(1);
      chk("t2_err_drop",  {31'd0, err_o}, 0);
      chk("t2_no_clr",    clr_cnt - c0, 0);

      // Continuous mode, gate 10: ack on second latch, no ack on third.
      k = cyc; cont = 1; gate_len = 10; count_in = 100; start = 1;
      exp_q.push_back('{32'd100, 1'b0, 1'b0, k + 15});
      exp_q.push_back('{32'd200, 1'b0, 1'b0, k + 29});
      exp_q.push_back('{32'd300, 1'b0, 1'b1, k + 43});
      tick(1); start = 0;
      tick(14); count_in = 200;
      tick(13); ack = 1;
      tick(1);  ack = 0; count_in = 300;
      tick(13); cont = 0;
      tick(1);
      wait_idle(20);
      chk("t3_ovr_sticky", {31'd0, overrun_o}, 1);

      // Abort on gate cycle 5 of 20, with an ignored start during the gate.
      k = cyc; e0 = en_cnt;
      gate_len = 20; start = 1; tick(1); start = 0;
      chk("t4_ovr_cleared", {31'd0, overrun_o}, 0);
      chk("t4_busy",        {31'd0, busy_o}, 1);
      tick(2); start = 1; gate_len = 5;
      tick(1); start = 0;
      tick(2); abort = 1;
      tick(1); abort = 0;
      chk("t4_en_low",     {31'd0, counter_en_o}, 0);
      chk("t4_idle",       {31'd0, busy_o}, 0);
      chk("t4_valid_kept", {31'd0, result_valid_o}, 1);
      chk("t4_result_kept", result_o, 300);
      chk("t4_en_cycles",  en_cnt - e0, 5);

      // Saturated count, unacked previous result, start ignored mid-gate.
      k = cyc; e0 = en_cnt;
      gate_len = 20; count_in = 32'hFFFF_FFFF; start = 1;
      exp_q.push_back('{32'hFFFF_FFFF, 1'b1, 1'b1, k + 25});
      tick(1); start = 0;
      tick(2); start = 1; gate_len = 3;
      tick(1); start = 0;
      wait_idle(60);
      chk("t5_en_cycles", en_cnt - e0, 20);
      ack = 1; tick(1); ack = 0;

      // Follow-up latch of 7 clears saturation.
      k = cyc; count_in = 7; gate_len = 3; start = 1;
      exp_q.push_back('{32'd7, 1'b0, 1'b0, k + 8});
      tick(1); start = 0;
      wait_idle(30);

      // Reset asserted mid-gate.
      gate_len = 30; start = 1; tick(1); start = 0;
      tick(5);
      rst_n = 1'b0; #1;
      e0 = en_cnt; c0 = clr_cnt;
      chk("t7_en",    {31'd0, counter_en_o},   0);
      chk("t7_clr",   {31'd0, counter_clr_o},  0);
      chk("t7_busy",  {31'd0, busy_o},         0);
      chk("t7_valid", {31'd0, result_valid_o}, 0);
      chk("t7_res",   result_o,                0);
      chk("t7_sat",   {31'd0, sat_o},          0);
      tick(2); rst_n = 1'b1;
      tick(10);
      chk("t7_quiet_busy", {31'd0, busy_o}, 0);
      chk("t7_quiet_clr",  clr_cnt - c0, 0);
      chk("t7_quiet_en",   en_cnt - e0, 0);

      chk("scoreboard_left", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
